// File: rtl/dp_uram_polyvec_burst_pkg.sv
// Shared definitions for the polyvec burst store: FSM encoding and read latency.
// Read latency grows by one when DP_URAM_OUTREG_EN is defined.
package dp_uram_polyvec_burst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } burst_state_e;

`ifdef DP_URAM_OUTREG_EN
   localparam int OUTREG_STAGES = 1;
`else
   localparam int OUTREG_STAGES = 0;
`endif

   // Cycles from address issue to rd_valid: URAM read register, NBPIPE stages, optional output register.
   function automatic int rd_lat(input int uram_delay);
      return 1 + uram_delay + OUTREG_STAGES;
   endfunction

endpackage

// File: rtl/dp_uram_burst_ctrl.sv
// Burst engine: command latch, FSM, beat counter, URAM address generation
// and the valid/last shift register that tracks read latency.
module dp_uram_burst_ctrl
   import dp_uram_polyvec_burst_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_POLY   = 3,
   parameter int SLOT_WIDTH = 1,
   parameter int URAM_DELAY = 1
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            cmd_valid_i,
   input  logic                            cmd_we_i,
   input  logic [SLOT_WIDTH-1:0]           cmd_slot_i,
   input  logic [ADDR_WIDTH-1:0]           cmd_base_i,
   input  logic [ADDR_WIDTH-1:0]           cmd_len_i,
   input  logic [NUM_POLY-1:0]             cmd_mask_i,
   input  logic                            wr_valid_i,
   output logic                            wr_ready_o,
   output logic [NUM_POLY-1:0]             mem_en_o,
   output logic                            mem_we_o,
   output logic [SLOT_WIDTH+ADDR_WIDTH-1:0] mem_addr_o,
   output logic [NUM_POLY-1:0]             mask_o,
   output logic                            dout_vld_o,
   output logic                            rd_valid_o,
   output logic                            rd_last_o,
   output logic                            done_o,
   output burst_state_e                    state_o
);

   localparam int RD_LAT = rd_lat(URAM_DELAY);

   burst_state_e          state_q;
   logic [SLOT_WIDTH-1:0] slot_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] len_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic [ADDR_WIDTH-1:0] cnt_d;
   logic [NUM_POLY-1:0]   mask_q;
   logic [RD_LAT-1:0]     vld_sr_q;
   logic [RD_LAT-1:0]     last_sr_q;
   logic                  wr_done_q;
   logic                  last_beat;
   logic                  wr_fire;
   logic                  rd_issue;

   // len 0 wraps to all-ones here, so a full 2^ADDR_WIDTH burst falls out naturally.
   assign last_beat = (cnt_q == (len_q - ADDR_WIDTH'(1)));
   assign cnt_d     = cnt_q + ADDR_WIDTH'(1);
   assign wr_fire   = (state_q == ST_WRITE) && wr_valid_i;
   assign rd_issue  = (state_q == ST_READ);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         slot_q    <= '0;
         base_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         mask_q    <= '0;
         vld_sr_q  <= '0;
         last_sr_q <= '0;
         wr_done_q <= 1'b0;
      end else begin
         wr_done_q <= 1'b0;
         for (int k = RD_LAT-1; k > 0; k--) begin
            vld_sr_q[k]  <= vld_sr_q[k-1];
            last_sr_q[k] <= last_sr_q[k-1];
         end
         vld_sr_q[0]  <= rd_issue;
         last_sr_q[0] <= rd_issue && last_beat;

         case (state_q)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  slot_q  <= cmd_slot_i;
                  base_q  <= cmd_base_i;
                  len_q   <= cmd_len_i;
                  mask_q  <= cmd_mask_i;
                  cnt_q   <= '0;
                  state_q <= cmd_we_i ? ST_WRITE : ST_READ;
               end
            end
            ST_WRITE: begin
               if (wr_valid_i) begin
                  cnt_q <= cnt_d;
                  if (last_beat) begin
                     state_q   <= ST_IDLE;
                     wr_done_q <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               cnt_q <= cnt_d;
               if (last_beat) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (last_sr_q[RD_LAT-1]) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign wr_ready_o = (state_q == ST_WRITE);
   assign mem_we_o   = (state_q == ST_WRITE);
   assign mem_en_o   = wr_fire ? mask_q : (rd_issue ? {NUM_POLY{1'b1}} : '0);
   assign mem_addr_o = {slot_q, base_q + cnt_q};
   assign mask_o     = mask_q;
   assign dout_vld_o = vld_sr_q[URAM_DELAY];
   assign rd_valid_o = vld_sr_q[RD_LAT-1];
   assign rd_last_o  = last_sr_q[RD_LAT-1];
   assign done_o     = wr_done_q | (vld_sr_q[RD_LAT-1] & last_sr_q[RD_LAT-1]);
   assign state_o    = state_q;

endmodule

// File: rtl/sp_uram.sv
// Single-port URAM model: registered read followed by NBPIPE pipeline stages.
module sp_uram #(
   parameter int AWIDTH = 13,
   parameter int DEPTH  = 8192,
   parameter int DWIDTH = 35,
   parameter int NBPIPE = 1
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [AWIDTH-1:0] addr_i,
   input  logic [DWIDTH-1:0] din_i,
   output logic [DWIDTH-1:0] dout_o
);

   logic [DWIDTH-1:0] mem    [DEPTH];
   logic [DWIDTH-1:0] pipe_q [NBPIPE+1];

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem[addr_i] <= din_i;
         end else begin
            pipe_q[0] <= mem[addr_i];
         end
      end
      for (int k = 1; k <= NBPIPE; k++) begin
         pipe_q[k] <= pipe_q[k-1];
      end
   end

   assign dout_o = pipe_q[NBPIPE];

endmodule

// File: rtl/dp_uram_polyvec_burst.sv
// Polyvec coefficient store: NUM_POLY URAM channels, NUM_SLOT polynomials each,
// driven by a burst engine. Define DP_URAM_OUTREG_EN to register the read outputs.
module dp_uram_polyvec_burst
   import dp_uram_polyvec_burst_pkg::*;
#(
   parameter int COE_WIDTH  = 35,
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_POLY   = 3,
   parameter int NUM_SLOT   = 2,
   parameter int SLOT_WIDTH = 1,
   parameter int URAM_DELAY = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_we,
   input  logic [SLOT_WIDTH-1:0]         cmd_slot,
   input  logic [ADDR_WIDTH-1:0]         cmd_base,
   input  logic [ADDR_WIDTH-1:0]         cmd_len,
   input  logic [NUM_POLY-1:0]           cmd_mask,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [NUM_POLY*COE_WIDTH-1:0] wr_data,
   output logic                          rd_valid,
   output logic [NUM_POLY*COE_WIDTH-1:0] rd_data,
   output logic                          rd_last,
   output logic                          busy,
   output logic                          done
);

   localparam int MEM_AW = SLOT_WIDTH + ADDR_WIDTH;
   localparam int DEPTH  = NUM_SLOT << ADDR_WIDTH;

   burst_state_e                  ctrl_state;
   logic [NUM_POLY-1:0]           mem_en;
   logic                          mem_we;
   logic [MEM_AW-1:0]             mem_addr;
   logic [NUM_POLY-1:0]           mask;
   logic                          dout_vld;
   logic [NUM_POLY*COE_WIDTH-1:0] dout;
   logic [NUM_POLY*COE_WIDTH-1:0] rd_data_d;

   dp_uram_burst_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_POLY   (NUM_POLY),
      .SLOT_WIDTH (SLOT_WIDTH),
      .URAM_DELAY (URAM_DELAY)
   ) u_ctrl (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_we_i    (cmd_we),
      .cmd_slot_i  (cmd_slot),
      .cmd_base_i  (cmd_base),
      .cmd_len_i   (cmd_len),
      .cmd_mask_i  (cmd_mask),
      .wr_valid_i  (wr_valid),
      .wr_ready_o  (wr_ready),
      .mem_en_o    (mem_en),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mask_o      (mask),
      .dout_vld_o  (dout_vld),
      .rd_valid_o  (rd_valid),
      .rd_last_o   (rd_last),
      .done_o      (done),
      .state_o     (ctrl_state)
   );

   assign cmd_ready = (ctrl_state == ST_IDLE);
   assign busy      = (ctrl_state != ST_IDLE);

   for (genvar i = 0; i < NUM_POLY; i++) begin : g_ch
      sp_uram #(
         .AWIDTH (MEM_AW),
         .DEPTH  (DEPTH),
         .DWIDTH (COE_WIDTH),
         .NBPIPE (URAM_DELAY)
      ) u_ram (
         .clk_i  (clk),
         .en_i   (mem_en[i]),
         .we_i   (mem_we),
         .addr_i (mem_addr),
         .din_i  (wr_data[i*COE_WIDTH +: COE_WIDTH]),
         .dout_o (dout[i*COE_WIDTH +: COE_WIDTH])
      );
   end

   // Zero outside valid beats and on masked-off channels, so stale URAM output never leaks.
   always_comb begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_POLY; i++) begin
         if (dout_vld && mask[i]) begin
            rd_data_d[i*COE_WIDTH +: COE_WIDTH] = dout[i*COE_WIDTH +: COE_WIDTH];
         end
      end
   end

`ifdef DP_URAM_OUTREG_EN
   logic [NUM_POLY*COE_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;
`else
   assign rd_data = rd_data_d;
`endif

endmodule
